// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, TX state encoding and the divisor floor.
// Latency: n/a (declarations only). Backpressure: n/a.
package mmio_pkg;

   // Word offsets selected by aluout[3:2]
   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;

   // STATUS register layout
   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;

   // A bit period shorter than two cycles cannot be represented by the counter scheme
   localparam logic [15:0] DIV_MIN = 16'd2;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < DIV_MIN) ? DIV_MIN : v;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port as seen by an MMIO peripheral: store strobe, address,
// store data, combinational read data and window select.
// Latency: none (wires only). Backpressure: none, the core never stalls.
interface mmio_uart_tx_if;
   logic        memwrite;
   logic [31:0] aluout;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        sel;

   modport master (
      output memwrite, aluout, writedata,
      input  readdata, sel
   );

   modport slave (
      input  memwrite, aluout, writedata,
      output readdata, sel
   );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO, power-of-two depth; push, pop, full, empty, count.
// Latency: pushed data visible at dout the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens on the same edge.
module uart_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,   // async, active-low
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // When full, the slot being vacated by a same-edge pop is the one written
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; only pointers and count define validity
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS/DIV register window, TX FIFO, 8N1 serialiser.
// Latency: store at edge k to idle block -> txd start bit after edge k+1; reads combinational.
// Backpressure: none to the core; a store to a full FIFO is dropped and sets sticky overflow.
// Ports: clk, reset (async active-low), bus (slave modport: memwrite/aluout/writedata in,
//        readdata/sel out), txd (serial out, idle high).
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter logic [15:0] CLKS_PER_BIT = 16'd434,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic           clk,
   input  logic           reset,
   mmio_uart_tx_if.slave  bus,
   output logic           txd
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // ---------------- decode ----------------
   logic [1:0] off;
   logic       wr;
   logic       wr_tx;
   logic       wr_st;
   logic       wr_div;

   assign off     = bus.aluout[3:2];
   assign bus.sel = (bus.aluout[31:4] == BASE_ADDR[31:4]);
   assign wr      = bus.memwrite & bus.sel;
   assign wr_tx   = wr & (off == OFF_TXDATA);
   assign wr_st   = wr & (off == OFF_STATUS);
   assign wr_div  = wr & (off == OFF_DIV);

   // Address byte lane and upper store bits have no register behind them
   logic unused_bits;
   assign unused_bits = ^{bus.writedata[31:16], bus.aluout[1:0]};

   // ---------------- FIFO ----------------
   logic [7:0]    f_dout;
   logic          f_full;
   logic          f_empty;
   logic [CW-1:0] f_count;
   logic          f_pop;

   uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_tx),
      .pop   (f_pop),
      .din   (bus.writedata[7:0]),
      .dout  (f_dout),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   // ---------------- control registers ----------------
   logic [15:0] div_q;
   logic        ovf;
   logic        ovf_set;

   // Dropped only when full and the serialiser is not freeing a slot this edge
   assign ovf_set = wr_tx & f_full & ~f_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q <= CLKS_PER_BIT;
         ovf   <= 1'b0;
      end else begin
         if (wr_div) div_q <= clamp_div(bus.writedata[15:0]);
         if (ovf_set)
            ovf <= 1'b1;
         else if (wr_st && bus.writedata[ST_OVF])
            ovf <= 1'b0;
      end
   end

   // ---------------- TX FSM ----------------
   tx_state_e   state, state_nxt;
   logic [7:0]  shreg, shreg_nxt;
   logic [2:0]  bit_idx, bit_idx_nxt;
   logic [15:0] bit_cnt, bit_cnt_nxt;
   logic [15:0] per, per_nxt;       // bit period latched at frame start
   logic        txd_q, txd_nxt;
   logic        tick;
   logic        load;

   assign tick = (bit_cnt == 16'd0);

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_idx_nxt = bit_idx;
      bit_cnt_nxt = bit_cnt;
      per_nxt     = per;
      load        = 1'b0;
      f_pop       = 1'b0;
      txd_nxt     = 1'b1;

      case (state)
         TX_IDLE: begin
            if (!f_empty) load = 1'b1;
         end
         TX_START: begin
            if (tick) begin
               state_nxt   = TX_DATA;
               bit_idx_nxt = 3'd0;
               bit_cnt_nxt = per - 16'd1;
            end else begin
               bit_cnt_nxt = bit_cnt - 16'd1;
            end
         end
         TX_DATA: begin
            if (tick) begin
               bit_cnt_nxt = per - 16'd1;
               if (bit_idx == 3'd7) state_nxt   = TX_STOP;
               else                 bit_idx_nxt = bit_idx + 3'd1;
            end else begin
               bit_cnt_nxt = bit_cnt - 16'd1;
            end
         end
         TX_STOP: begin
            if (tick) begin
               // Chain straight into the next start bit when more data waits
               if (!f_empty) load = 1'b1;
               else          state_nxt = TX_IDLE;
            end else begin
               bit_cnt_nxt = bit_cnt - 16'd1;
            end
         end
         default: state_nxt = TX_IDLE;
      endcase

      // Frame start: DIV sampled here so mid-frame DIV writes wait for the next frame
      if (load) begin
         f_pop       = 1'b1;
         state_nxt   = TX_START;
         shreg_nxt   = f_dout;
         per_nxt     = div_q;
         bit_cnt_nxt = div_q - 16'd1;
      end

      // txd is registered from the next state so the line never glitches
      case (state_nxt)
         TX_START: txd_nxt = 1'b0;
         TX_DATA:  txd_nxt = shreg_nxt[bit_idx_nxt];
         default:  txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= TX_IDLE;
         shreg   <= 8'h00;
         bit_idx <= 3'd0;
         bit_cnt <= 16'd0;
         per     <= CLKS_PER_BIT;
         txd_q   <= 1'b1;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_idx <= bit_idx_nxt;
         bit_cnt <= bit_cnt_nxt;
         per     <= per_nxt;
         txd_q   <= txd_nxt;
      end
   end

   assign txd = txd_q;

   // ---------------- read mux ----------------
   logic [31:0] status;
   logic [31:0] rd;

   always_comb begin
      status                     = 32'h0;
      status[ST_FULL]            = f_full;
      status[ST_EMPTY]           = f_empty;
      status[ST_BUSY]            = (state != TX_IDLE);
      status[ST_OVF]             = ovf;
      status[ST_CNT_LSB +: CW]   = f_count;

      rd = 32'h0;
      if (bus.sel) begin
         case (off)
            OFF_STATUS: rd = status;
            OFF_DIV:    rd = {16'h0, div_q};
            default:    rd = 32'h0;
         endcase
      end
   end

   assign bus.readdata = rd;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register reads, 8N1 waveform against a
// frame-level model, FIFO fill/overflow, DIV clamping and latching, async reset.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam logic [31:0] A_TX  = BASE;
   localparam logic [31:0] A_ST  = BASE + 32'd4;
   localparam logic [31:0] A_DIV = BASE + 32'd8;
   localparam logic [31:0] A_RSV = BASE + 32'd12;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic txd;

   int checks = 0;
   int errors = 0;

   // Expected txd, one entry per cycle, sampled at successive falling edges
   logic exp_q[$];

   mmio_uart_tx_if bus();

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (16'd434),
      .FIFO_DEPTH   (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .txd   (txd)
   );

   always #5 clk = ~clk;

   // ---------------- bus helpers ----------------
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.aluout    = a;
      bus.writedata = d;
      bus.memwrite  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.memwrite  = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus.memwrite = 1'b0;
      bus.aluout   = a;
      #1;
      d = bus.readdata;
   endtask

   // ---------------- reference model ----------------
   // An 8N1 frame is start(0), eight data bits LSB first, stop(1), each div cycles.
   task automatic add_frame(input logic [7:0] b, input int div);
      logic v;
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      v = 1'b0;
         else if (k == 9) v = 1'b1;
         else             v = b[k-1];
         for (int c = 0; c < div; c++) exp_q.push_back(v);
      end
   endtask

   task automatic add_idle(input int n);
      for (int c = 0; c < n; c++) exp_q.push_back(1'b1);
   endtask

   // Status word from the register-level view of the spec
   function automatic logic [31:0] status_word(input int cnt, input bit busy, input bit ovf);
      logic [31:0] s;
      s = 32'h0;
      s[0]   = (cnt == 8);
      s[1]   = (cnt == 0);
      s[2]   = busy;
      s[3]   = ovf;
      s[8:4] = 5'(cnt);
      return s;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] d;
      bus.memwrite  = 1'b0;
      bus.aluout    = 32'h0;
      bus.writedata = 32'h0;
      reset         = 1'b0;
      #12;
      bus_read(A_ST, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL reset_status_in_reset got %h exp %h", d, 32'h2); end
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bus_read(A_ST, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp %h", d, 32'h2); end
      checks++;
      if (bus.sel !== 1'b1) begin errors++; $display("FAIL sel_in_window got %b exp 1", bus.sel); end
      bus_read(A_DIV, d);
      checks++;
      if (d !== 32'd434) begin errors++; $display("FAIL reset_div got %0d exp 434", d); end
      bus_read(A_RSV, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reserved_read got %h exp 0", d); end
      bus_read(A_TX, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL txdata_read got %h exp 0", d); end
      bus_read(32'h1000_0004, d);
      checks++;
      if (d !== 32'h0 || bus.sel !== 1'b0) begin
         errors++; $display("FAIL unselected_read got %h sel %b exp 0 sel 0", d, bus.sel);
      end
      // Stores outside the window must leave DIV alone
      bus_write(32'h0000_0008, 32'd7);
      bus_read(A_DIV, d);
      checks++;
      if (d !== 32'd434) begin errors++; $display("FAIL unselected_write_div got %0d exp 434", d); end
   endtask

   task automatic test_single_frame(input logic [7:0] b);
      logic [31:0] d;
      @(negedge clk);
      exp_q.delete();
      add_frame(b, 4);
      add_idle(2);
      bus_write(A_DIV, 32'd4);
      bus_write(A_TX, {24'h0, b});
      bus_read(A_ST, d);
      checks++;
      if (d !== status_word(1, 1'b0, 1'b0)) begin
         errors++; $display("FAIL single_count_after_store got %h exp %h", d, status_word(1, 1'b0, 1'b0));
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         bus_read(A_ST, d);
         checks++;
         if (txd !== exp_q[i]) begin
            errors++; $display("FAIL single_txd byte %h cycle %0d got %b exp %b", b, i, txd, exp_q[i]);
         end
         checks++;
         if (d[2] !== (i < 40)) begin
            errors++; $display("FAIL single_busy cycle %0d got %b exp %b", i, d[2], (i < 40));
         end
      end
   endtask

   task automatic test_div();
      logic [31:0] d;
      logic [15:0] r;
      logic [7:0]  a, b;
      @(negedge clk);
      bus_write(A_DIV, 32'd0);
      bus_read(A_DIV, d);
      checks++;
      if (d !== 32'd2) begin errors++; $display("FAIL div_clamp0 got %0d exp 2", d); end
      bus_write(A_DIV, 32'd1);
      bus_read(A_DIV, d);
      checks++;
      if (d !== 32'd2) begin errors++; $display("FAIL div_clamp1 got %0d exp 2", d); end
      bus_write(A_DIV, 32'hABCD_0007);
      bus_read(A_DIV, d);
      checks++;
      if (d !== 32'd7) begin errors++; $display("FAIL div_upper_ignored got %h exp 7", d); end
      r = 16'($urandom_range(2, 60000));
      bus_write(A_DIV, {16'hFFFF, r});
      bus_read(A_DIV, d);
      checks++;
      if (d !== {16'h0, r}) begin errors++; $display("FAIL div_random got %h exp %h", d, r); end

      // A DIV write mid-frame only affects the following frame
      bus_write(A_DIV, 32'd3);
      a = 8'($urandom);
      b = 8'($urandom);
      exp_q.delete();
      add_idle(1);
      add_frame(a, 3);
      add_frame(b, 5);
      add_idle(4);
      fork
         begin
            bus_write(A_TX, {24'h0, a});
            bus_write(A_TX, {24'h0, b});
            repeat (3) @(negedge clk);
            bus_write(A_DIV, 32'd5);
            bus_read(A_DIV, d);
            checks++;
            if (d !== 32'd5) begin errors++; $display("FAIL div_midframe_read got %0d exp 5", d); end
         end
         begin
            for (int i = 0; i < exp_q.size(); i++) begin
               @(negedge clk);
               checks++;
               if (txd !== exp_q[i]) begin
                  errors++; $display("FAIL div_midframe_txd cycle %0d got %b exp %b", i, txd, exp_q[i]);
               end
            end
         end
      join
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [7:0]  bytes [9];
      @(negedge clk);
      bus_write(A_DIV, 32'd2);
      for (int i = 0; i < 9; i++) bytes[i] = 8'($urandom);
      exp_q.delete();
      add_idle(1);
      for (int i = 0; i < 9; i++) add_frame(bytes[i], 2);
      add_idle(10);
      fork
         begin
            for (int i = 0; i < 9; i++) bus_write(A_TX, {24'h0, bytes[i]});
            bus_read(A_ST, d);
            checks++;
            if (d !== status_word(8, 1'b1, 1'b0)) begin
               errors++; $display("FAIL b2b_full_no_ovf got %h exp %h", d, status_word(8, 1'b1, 1'b0));
            end
            bus_write(A_TX, 32'h0000_00C3);
            bus_read(A_ST, d);
            checks++;
            if (d !== status_word(8, 1'b1, 1'b1)) begin
               errors++; $display("FAIL b2b_ovf_set got %h exp %h", d, status_word(8, 1'b1, 1'b1));
            end
            bus_write(A_ST, 32'h8);
            bus_read(A_ST, d);
            checks++;
            if (d !== status_word(8, 1'b1, 1'b0)) begin
               errors++; $display("FAIL b2b_ovf_clear got %h exp %h", d, status_word(8, 1'b1, 1'b0));
            end
         end
         begin
            for (int i = 0; i < exp_q.size(); i++) begin
               @(negedge clk);
               checks++;
               if (txd !== exp_q[i]) begin
                  errors++; $display("FAIL b2b_txd cycle %0d got %b exp %b", i, txd, exp_q[i]);
               end
            end
         end
      join
      bus_read(A_ST, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL b2b_drained got %h exp 2", d); end
   endtask

   task automatic test_full_pop_edge();
      logic [31:0] d;
      logic [7:0]  bytes [10];
      @(negedge clk);
      bus_write(A_DIV, 32'd2);
      for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
      exp_q.delete();
      add_idle(1);
      for (int i = 0; i < 10; i++) add_frame(bytes[i], 2);
      add_idle(5);
      fork
         begin
            // First frame starts one edge after the first store and ends 20 edges later
            for (int i = 0; i < 9; i++) bus_write(A_TX, {24'h0, bytes[i]});
            repeat (12) @(negedge clk);
            bus_read(A_ST, d);
            checks++;
            if (d !== status_word(8, 1'b1, 1'b0)) begin
               errors++; $display("FAIL popedge_before got %h exp %h", d, status_word(8, 1'b1, 1'b0));
            end
            bus_write(A_TX, {24'h0, bytes[9]});
            bus_read(A_ST, d);
            checks++;
            if (d !== status_word(8, 1'b1, 1'b0)) begin
               errors++; $display("FAIL popedge_after got %h exp %h", d, status_word(8, 1'b1, 1'b0));
            end
         end
         begin
            for (int i = 0; i < exp_q.size(); i++) begin
               @(negedge clk);
               checks++;
               if (txd !== exp_q[i]) begin
                  errors++; $display("FAIL popedge_txd cycle %0d got %b exp %b", i, txd, exp_q[i]);
               end
            end
         end
      join
   endtask

   task automatic test_random_frames();
      logic [31:0] d;
      int          dv;
      int          n;
      logic [7:0]  bytes [4];
      for (int it = 0; it < 3; it++) begin
         @(negedge clk);
         dv = $urandom_range(2, 6);
         n  = $urandom_range(1, 4);
         bus_write(A_DIV, 32'(dv));
         for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
         exp_q.delete();
         add_idle(1);
         for (int i = 0; i < n; i++) add_frame(bytes[i], dv);
         add_idle(3);
         fork
            begin
               for (int i = 0; i < n; i++) bus_write(A_TX, {24'h0, bytes[i]});
            end
            begin
               for (int i = 0; i < exp_q.size(); i++) begin
                  @(negedge clk);
                  checks++;
                  if (txd !== exp_q[i]) begin
                     errors++;
                     $display("FAIL random_txd iter %0d div %0d cycle %0d got %b exp %b", it, dv, i, txd, exp_q[i]);
                  end
               end
            end
         join
         bus_read(A_ST, d);
         checks++;
         if (d !== 32'h2) begin errors++; $display("FAIL random_idle iter %0d got %h exp 2", it, d); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [7:0]  b;
      @(negedge clk);
      b = 8'($urandom) & 8'hF7;   // data bit 3 low so the line is 0 when reset hits
      bus_write(A_DIV, 32'd4);
      bus_write(A_TX, {24'h0, b});
      bus_write(A_TX, 32'h0000_005A);
      // Now one cycle into the start bit; bit 3 occupies frame cycles 16..19
      repeat (17) @(negedge clk);
      checks++;
      if (txd !== 1'b0) begin errors++; $display("FAIL rstmid_pre_txd got %b exp 0", txd); end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_async_txd got %b exp 1", txd); end
      bus_read(A_ST, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL rstmid_status_in_reset got %h exp 2", d); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         checks++;
         if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_residual cycle %0d got %b exp 1", i, txd); end
      end
      bus_read(A_ST, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL rstmid_status got %h exp 2", d); end
      bus_read(A_DIV, d);
      checks++;
      if (d !== 32'd434) begin errors++; $display("FAIL rstmid_div got %0d exp 434", d); end
   endtask

   initial begin
      test_reset();
      test_single_frame(8'hA5);
      test_single_frame(8'($urandom));
      test_div();
      test_back_to_back();
      test_full_pop_edge();
      test_random_frames();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
